ssg_datapath_scheduler: RTL

- Shares one fixed-latency SSG datapath instance between N_REQ requesters using round-robin arbitration.
- Enforces a minimum initiation interval between issues and tags each issue with its requester ID.
- Checks that each datapath completion arrives exactly LATENCY cycles after its start, and returns the result strobe tagged with that ID.
- Sits between the SSG input collectors and the datapath; the datapath's own result bus bypasses this block.

---
 rtl/ssg_datapath_scheduler_if.sv | 27 ++
 rtl/ssg_datapath_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ssg_datapath_scheduler_if.sv
// Handshake and datapath bus between the SSG input collectors, the
// scheduler and the shared fixed-latency datapath.
interface ssg_datapath_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int WEIGHT = 5,
    parameter int WIDTH  = 2,
    parameter int IDW    = $clog2(N_REQ)
);
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ*WIDTH*WEIGHT-1:0] req_data;
    logic [N_REQ-1:0]              req_ready;
    logic                          dp_start;
    logic [WIDTH*WEIGHT-1:0]       dp_data;
    logic                          dp_done;
    logic                          rsp_valid;
    logic [IDW-1:0]                rsp_id;

    modport master (
        output req_valid, req_data, dp_done,
        input  req_ready, dp_start, dp_data, rsp_valid, rsp_id
    );

    modport slave (
        input  req_valid, req_data, dp_done,
        output req_ready, dp_start, dp_data, rsp_valid, rsp_id
    );
endinterface

// File: rtl/ssg_datapath_scheduler.sv
// Round-robin issue scheduler for one shared fixed-latency SSG datapath.
// Enforces a minimum initiation interval, tags every issue with its
// requester ID and checks that each completion lands exactly LATENCY
// cycles after its start.
module ssg_datapath_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WEIGHT  = 5,
    parameter int WIDTH   = 2,
    parameter int LATENCY = 11,
    parameter int II      = 1,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    ssg_datapath_scheduler_if.slave      bus,
    output logic                         err_pulse,
    output logic                         err_sticky,
    output logic [$clog2(LATENCY+1)-1:0] inflight,
    output logic                         busy
);
    localparam int BW = WIDTH * WEIGHT;
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [IDW-1:0]   ptr_r;
    logic [IDW-1:0]   idx_s;
    logic [IDW-1:0]   grant_id_s;
    logic             found_s;
    logic [N_REQ-1:0] grant_s;
    logic [BW-1:0]    data_sel_s;
    logic [3:0]       ii_cnt_r;
    logic             dp_start_r;
    logic [BW-1:0]    dp_data_r;
    logic [IDW-1:0]   dp_id_r;
    logic [LATENCY:1] track_v_r;
    logic [IDW-1:0]   track_id_r [1:LATENCY];
    logic             expected_s;
    logic             mismatch_s;
    logic             rsp_valid_r;
    logic [IDW-1:0]   rsp_id_r;
    logic             err_pulse_r;
    logic             err_sticky_r;
    logic [CW-1:0]    inflight_r;
    logic [CW-1:0]    inflight_next_s;
    logic             busy_r;

    // Round-robin pick of the first valid requester at or above the pointer.
    always_comb begin
        idx_s      = '0;
        grant_id_s = '0;
        found_s    = 1'b0;
        grant_s    = '0;
        data_sel_s = '0;
        if ((state_r == RUN) && enable && (ii_cnt_r == 4'd0)) begin
            for (int i = 0; i < N_REQ; i++) begin
                // Wrap ptr+i back into 0..N_REQ-1 without a modulo.
                if (ptr_r >= IDW'(N_REQ - i)) begin
                    idx_s = ptr_r - IDW'(N_REQ - i);
                end else begin
                    idx_s = ptr_r + IDW'(i);
                end
                if (!found_s && bus.req_valid[idx_s]) begin
                    found_s    = 1'b1;
                    grant_id_s = idx_s;
                end else begin
                    found_s    = found_s;
                end
            end
            if (found_s) begin
                grant_s[grant_id_s] = 1'b1;
            end else begin
                grant_s = '0;
            end
        end else begin
            grant_s = '0;
        end
        for (int r = 0; r < N_REQ; r++) begin
            if (grant_s[r]) begin
                data_sel_s = bus.req_data[r*BW +: BW];
            end else begin
                data_sel_s = data_sel_s;
            end
        end
    end

    // Next state, outstanding-count update and retirement decision.
    always_comb begin
        state_next_s = state_r;
        expected_s   = track_v_r[LATENCY];
        mismatch_s   = track_v_r[LATENCY] ^ bus.dp_done;
        case (state_r)
            IDLE: begin
                if (enable) state_next_s = RUN;
                else        state_next_s = IDLE;
            end
            RUN: begin
                if (!enable) state_next_s = DRAIN;
                else         state_next_s = RUN;
            end
            DRAIN: begin
                // A start still in flight towards the tracker keeps DRAIN alive.
                if (enable)                                       state_next_s = RUN;
                else if ((inflight_r == '0) && !dp_start_r)       state_next_s = IDLE;
                else                                              state_next_s = DRAIN;
            end
            default: state_next_s = IDLE;
        endcase
        case ({dp_start_r, expected_s})
            2'b10:   inflight_next_s = inflight_r + CNT_ONE;
            2'b01:   inflight_next_s = inflight_r - CNT_ONE;
            default: inflight_next_s = inflight_r;
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            inflight_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            inflight_r <= inflight_next_s;
            busy_r     <= (state_next_s != IDLE) || (inflight_next_s != '0);
        end
    end

    // Issue path: pointer advance, II spacing and registered datapath start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r      <= '0;
            ii_cnt_r   <= 4'd0;
            dp_start_r <= 1'b0;
            dp_data_r  <= '0;
            dp_id_r    <= '0;
        end else if (found_s) begin
            ptr_r      <= (grant_id_s == IDW'(N_REQ - 1)) ? '0 : grant_id_s + IDW'(1);
            ii_cnt_r   <= 4'(II - 1);
            dp_start_r <= 1'b1;
            dp_data_r  <= data_sel_s;
            dp_id_r    <= grant_id_s;
        end else begin
            ptr_r      <= ptr_r;
            ii_cnt_r   <= (ii_cnt_r != 4'd0) ? ii_cnt_r - 4'd1 : ii_cnt_r;
            dp_start_r <= 1'b0;
            dp_data_r  <= dp_data_r;
            dp_id_r    <= dp_id_r;
        end
    end

    // Age tracker: the start register is age 0, element k holds age k.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            track_v_r <= '0;
            for (int k = 1; k <= LATENCY; k++) begin
                track_id_r[k] <= '0;
            end
        end else begin
            track_v_r[1]  <= dp_start_r;
            track_id_r[1] <= dp_id_r;
            for (int k = 2; k <= LATENCY; k++) begin
                track_v_r[k]  <= track_v_r[k-1];
                track_id_r[k] <= track_id_r[k-1];
            end
        end
    end

    // Completion check: match returns the tag, any mismatch flags an error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            err_pulse_r  <= 1'b0;
            err_sticky_r <= 1'b0;
        end else begin
            rsp_valid_r  <= expected_s & bus.dp_done;
            rsp_id_r     <= (expected_s & bus.dp_done) ? track_id_r[LATENCY] : rsp_id_r;
            err_pulse_r  <= mismatch_s;
            err_sticky_r <= err_sticky_r | mismatch_s;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.dp_start  = dp_start_r;
    assign bus.dp_data   = dp_data_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign err_pulse     = err_pulse_r;
    assign err_sticky    = err_sticky_r;
    assign inflight      = inflight_r;
    assign busy          = busy_r;
endmodule
